// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    StWait,
    StRelease,
    StRun
  } prs_state_t;

  localparam int unsigned LOSS_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with synchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds downstream domains in reset until PLL lock is stable, then releases them in order.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_GAP          = 64,
  parameter int unsigned N_STAGES           = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock_i,
  output logic [N_STAGES-1:0]   rst_out,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int unsigned GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int unsigned IW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] STAGE_LAST  = IW'(N_STAGES - 1);

  logic                  lock_s;
  prs_state_t            state_q, state_d;
  logic [SW-1:0]         stable_q, stable_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [IW-1:0]         stage_q, stage_d;
  logic [N_STAGES-1:0]   rst_out_q, rst_out_d;
  logic                  ready_q, ready_d;
  logic                  loss_q, loss_d;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock_i),
    .q   (lock_s)
  );

  always_comb begin
    state_d    = state_q;
    stable_d   = stable_q;
    gap_d      = gap_q;
    stage_d    = stage_q;
    rst_out_d  = rst_out_q;
    ready_d    = ready_q;
    loss_d     = 1'b0;
    loss_cnt_d = loss_cnt_q;

    // A loss seen on lock_s is acted on one edge later, giving t+3 from the raw input.
    if (loss_q) begin
      state_d   = StWait;
      stable_d  = '0;
      gap_d     = '0;
      stage_d   = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
      if (loss_cnt_q != '1) begin
        loss_cnt_d = loss_cnt_q + 1'b1;
      end
    end else begin
      unique case (state_q)
        StWait: begin
          rst_out_d = '1;
          ready_d   = 1'b0;
          if (!lock_s) begin
            stable_d = '0;
          end else if (stable_q == STABLE_LAST) begin
            state_d  = StRelease;
            stable_d = '0;
            gap_d    = '0;
            stage_d  = '0;
          end else begin
            stable_d = stable_q + 1'b1;
          end
        end

        StRelease: begin
          loss_d = !lock_s;
          // Stages 0..stage_q released; contiguity holds by construction.
          for (int unsigned i = 0; i < N_STAGES; i++) begin
            rst_out_d[i] = (i > int'(stage_q));
          end
          if (stage_q == STAGE_LAST) begin
            if (!rst_out_q[N_STAGES-1]) begin
              state_d = StRun;
              ready_d = 1'b1;
            end
          end else if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            stage_d = stage_q + 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end

        StRun: begin
          loss_d    = !lock_s;
          rst_out_d = '0;
          ready_d   = 1'b1;
        end

        default: begin
          state_d = StWait;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StWait;
      stable_q   <= '0;
      gap_q      <= '0;
      stage_q    <= '0;
      rst_out_q  <= '1;
      ready_q    <= 1'b0;
      loss_q     <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stable_q   <= stable_d;
      gap_q      <= gap_d;
      stage_q    <= stage_d;
      rst_out_q  <= rst_out_d;
      ready_q    <= ready_d;
      loss_q     <= loss_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign rst_out       = rst_out_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_cnt_q;

endmodule
